// File: rtl/game_round_ctrl_pkg.sv
// Shared types and constants for the BCD math game round sequencer.
// Holds the FSM state encoding, BCD limits and the player ID width.
package game_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOGGED = 3'd1,
        ST_START  = 3'd2,
        ST_PLAY   = 3'd3,
        ST_TOUT   = 3'd4,
        ST_SCORE  = 3'd5
    } state_t;

    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam int         PLAYER_ID_W = 5;

    // Two-digit BCD image of a binary value in 0..99.
    function automatic logic [7:0] to_bcd2(input int unsigned v);
        to_bcd2 = {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/game_round_ctrl_bcd_down_counter.sv
// Two-digit BCD down counter for the round timer display.
// Loads a BCD value, decrements with borrow, and saturates at 00.
module game_round_ctrl_bcd_down_counter
    import game_round_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [3:0] d10,
    output logic [3:0] d1,
    output logic       zero_next
);

    // High when the next decrement lands on 00.
    assign zero_next = (d10 == 4'd0) && (d1 == 4'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d10 <= 4'd0;
            d1  <= 4'd0;
        end else if (load) begin
            d10 <= load_val[7:4];
            d1  <= load_val[3:0];
        end else if (dec) begin
            if (d1 != 4'd0) begin
                d1 <= d1 - 4'd1;
            end else if (d10 != 4'd0) begin
                d1  <= BCD_MAX;
                d10 <= d10 - 4'd1;
            end
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the BCD math game: login, round timer, and the
// single-cycle datapath strobes driving the ALU and scoring logic.
module game_round_ctrl
    import game_round_ctrl_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int ROUND_SECS    = 30,
    parameter int NUM_PLAYERS   = 32,
    parameter int SCORE_LAT     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   login_req,
    input  logic [PLAYER_ID_W-1:0] login_id,
    input  logic                   logout_req,
    input  logic                   start_btn,
    input  logic                   enter_btn,
    input  logic [3:0]             digit_in,
    output logic                   Logged_In,
    output logic [PLAYER_ID_W-1:0] playerID,
    output logic                   Game_Start,
    output logic                   Load_Input,
    output logic [3:0]             Player_Input,
    output logic                   Timeout,
    output logic [3:0]             sec_D10,
    output logic [3:0]             sec_D1,
    output logic                   busy,
    output logic [2:0]             state_dbg
);

    localparam int PW    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SW    = (SCORE_LAT > 1) ? $clog2(SCORE_LAT) : 1;
    localparam int ID_W1 = PLAYER_ID_W + 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0]    SCORE_LAST = SW'(SCORE_LAT - 1);
    localparam logic [7:0]       ROUND_BCD  = to_bcd2(ROUND_SECS);
    localparam logic [ID_W1-1:0] ID_LIMIT   = ID_W1'(NUM_PLAYERS);

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     presc;
    logic [SW-1:0]     score_cnt;
    logic              presc_wrap;
    logic              id_ok;
    logic              digit_ok;
    logic              accept_digit;
    logic              cnt_load;
    logic              cnt_dec;
    logic              zero_next;

    // Strobe contract: Game_Start, Load_Input and Timeout are registered
    // one-cycle pulses with no back-pressure; Player_Input is valid while
    // Load_Input is high and is held until the next accepted digit.
    assign presc_wrap = (presc == PRESC_LAST);
    assign id_ok      = ({1'b0, login_id} < ID_LIMIT);
    assign digit_ok   = (digit_in <= BCD_MAX);
    assign busy       = (state == ST_START) || (state == ST_PLAY) ||
                        (state == ST_TOUT)  || (state == ST_SCORE);
    assign state_dbg  = state;

    always_comb begin
        state_next   = state;
        accept_digit = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (login_req && id_ok) state_next = ST_LOGGED;
            end
            ST_LOGGED: begin
                if (logout_req)     state_next = ST_IDLE;
                else if (start_btn) state_next = ST_START;
            end
            ST_START: begin
                cnt_load   = 1'b1;
                state_next = ST_PLAY;
            end
            ST_PLAY: begin
                cnt_dec = presc_wrap;
                // An enter on the expiry edge loses to the timeout.
                if (presc_wrap && zero_next) state_next = ST_TOUT;
                else                         accept_digit = enter_btn && digit_ok;
            end
            ST_TOUT: begin
                state_next = ST_SCORE;
            end
            ST_SCORE: begin
                if (score_cnt == SCORE_LAST) state_next = ST_LOGGED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Logged_In    <= 1'b0;
            playerID     <= '0;
            Game_Start   <= 1'b0;
            Load_Input   <= 1'b0;
            Player_Input <= 4'd0;
            Timeout      <= 1'b0;
            presc        <= '0;
            score_cnt    <= '0;
        end else begin
            Game_Start <= (state_next == ST_START);
            Timeout    <= (state_next == ST_TOUT);
            Load_Input <= accept_digit;
            if (accept_digit) Player_Input <= digit_in;

            if (state == ST_IDLE && state_next == ST_LOGGED) begin
                Logged_In <= 1'b1;
                playerID  <= login_id;
            end else if (state == ST_LOGGED && state_next == ST_IDLE) begin
                Logged_In <= 1'b0;
                playerID  <= '0;
            end

            if (state == ST_PLAY) presc <= presc_wrap ? '0 : presc + 1'b1;
            else                  presc <= '0;

            if (state == ST_SCORE) score_cnt <= score_cnt + 1'b1;
            else                   score_cnt <= '0;
        end
    end

    game_round_ctrl_bcd_down_counter u_secs (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .load_val  (ROUND_BCD),
        .dec       (cnt_dec),
        .d10       (sec_D10),
        .d1        (sec_D1),
        .zero_next (zero_next)
    );

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: a round-level reference model checked every
// cycle, directed scenarios with literal expectations, and a strobe-order log.
module tb_game_round_ctrl;

    localparam int TPS   = 4;
    localparam int ROUND = 12;
    localparam int NUM_P = 20;
    localparam int SLAT  = 4;

    localparam int P_IDLE   = 0;
    localparam int P_LOGGED = 1;
    localparam int P_START  = 2;
    localparam int P_PLAY   = 3;
    localparam int P_TOUT   = 4;
    localparam int P_SCORE  = 5;

    logic       clk;
    logic       rst_n;
    logic       login_req;
    logic [4:0] login_id;
    logic       logout_req;
    logic       start_btn;
    logic       enter_btn;
    logic [3:0] digit_in;
    logic       Logged_In;
    logic [4:0] playerID;
    logic       Game_Start;
    logic       Load_Input;
    logic [3:0] Player_Input;
    logic       Timeout;
    logic [3:0] sec_D10;
    logic [3:0] sec_D1;
    logic       busy;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int pos_cnt = 0;
    int base = 0;
    logic cmp_en = 1'b0;
    logic rec_en = 1'b0;

    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];

    // Reference model state: phase, integer seconds, and expected strobes.
    int   m_phase, m_secs, m_tick, m_score;
    logic m_logged;
    logic [4:0] m_id;
    logic e_gs, e_ld, e_to;
    logic [3:0] e_pi;

    game_round_ctrl #(
        .TICKS_PER_SEC (TPS),
        .ROUND_SECS    (ROUND),
        .NUM_PLAYERS   (NUM_P),
        .SCORE_LAT     (SLAT)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .login_req    (login_req),
        .login_id     (login_id),
        .logout_req   (logout_req),
        .start_btn    (start_btn),
        .enter_btn    (enter_btn),
        .digit_in     (digit_in),
        .Logged_In    (Logged_In),
        .playerID     (playerID),
        .Game_Start   (Game_Start),
        .Load_Input   (Load_Input),
        .Player_Input (Player_Input),
        .Timeout      (Timeout),
        .sec_D10      (sec_D10),
        .sec_D1       (sec_D1),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) pos_cnt <= pos_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_IDLE; m_secs <= 0; m_tick <= 0; m_score <= 0;
            m_logged <= 1'b0; m_id <= '0;
            e_gs <= 1'b0; e_ld <= 1'b0; e_to <= 1'b0; e_pi <= '0;
        end else begin
            e_gs <= 1'b0; e_ld <= 1'b0; e_to <= 1'b0;
            case (m_phase)
                P_IDLE: if (login_req && int'(login_id) < NUM_P) begin
                    m_logged <= 1'b1; m_id <= login_id; m_phase <= P_LOGGED;
                end
                P_LOGGED: begin
                    if (logout_req) begin
                        m_logged <= 1'b0; m_id <= '0; m_phase <= P_IDLE;
                    end else if (start_btn) begin
                        m_phase <= P_START; e_gs <= 1'b1;
                    end
                end
                P_START: begin
                    m_secs <= ROUND; m_tick <= 0; m_phase <= P_PLAY;
                end
                P_PLAY: begin
                    if (m_tick == TPS - 1) begin
                        m_tick <= 0; m_secs <= m_secs - 1;
                    end else begin
                        m_tick <= m_tick + 1;
                    end
                    if (m_tick == TPS - 1 && m_secs == 1) begin
                        m_phase <= P_TOUT; e_to <= 1'b1;
                    end else if (enter_btn && digit_in <= 4'd9) begin
                        e_ld <= 1'b1; e_pi <= digit_in;
                    end
                end
                P_TOUT: begin
                    m_phase <= P_SCORE; m_score <= 0;
                end
                P_SCORE: begin
                    if (m_score == SLAT - 1) m_phase <= P_LOGGED;
                    else                     m_score <= m_score + 1;
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_logged_in", Logged_In, m_logged);
            check("m_player_id", playerID, m_id);
            check("m_game_start", Game_Start, e_gs);
            check("m_load_input", Load_Input, e_ld);
            check("m_timeout", Timeout, e_to);
            check("m_player_input", Player_Input, e_pi);
            check("m_sec_d10", sec_D10, m_secs / 10);
            check("m_sec_d1", sec_D1, m_secs % 10);
            check("m_busy", busy, (m_phase >= P_START) ? 1 : 0);
        end
    end

    // Strobe-order recorder: 1=Game_Start, 2=Load_Input, 3=Timeout
    always @(negedge clk) begin
        if (rec_en) begin
            if (Game_Start) obs_q.push_back(2'd1);
            if (Load_Input) obs_q.push_back(2'd2);
            if (Timeout)    obs_q.push_back(2'd3);
        end
    end

    // Driver tasks: called at a negedge, return at the negedge after the sampling edge.
    task automatic pulse_login(input logic [4:0] id);
        login_req = 1'b1; login_id = id;
        @(negedge clk);
        login_req = 1'b0;
    endtask

    task automatic pulse_logout();
        logout_req = 1'b1;
        @(negedge clk);
        logout_req = 1'b0;
    endtask

    task automatic pulse_start();
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
    endtask

    task automatic pulse_enter(input logic [3:0] d);
        enter_btn = 1'b1; digit_in = d;
        @(negedge clk);
        enter_btn = 1'b0;
    endtask

    task automatic wait_until(input int k);
        while ((pos_cnt - base) < k) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; login_req = 1'b0; login_id = '0; logout_req = 1'b0;
        start_btn = 1'b0; enter_btn = 1'b0; digit_in = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_logged_in", Logged_In, 0);
        check("rst_player_id", playerID, 0);
        check("rst_busy", busy, 0);
        check("rst_sec", {sec_D10, sec_D1}, 8'h00);

        // Login 7, start, timer countdown with borrow
        pulse_login(5'd7);
        check("login7_logged", Logged_In, 1);
        check("login7_id", playerID, 7);
        pulse_start();
        base = pos_cnt;
        check("r1_game_start", Game_Start, 1);
        check("r1_busy", busy, 1);
        @(negedge clk);
        check("r1_gs_one_cycle", Game_Start, 0);
        check("r1_sec12", {sec_D10, sec_D1}, 8'h12);
        wait_until(5);
        check("r1_sec11", {sec_D10, sec_D1}, 8'h11);
        wait_until(12);
        check("r1_sec10", {sec_D10, sec_D1}, 8'h10);
        wait_until(13);
        check("r1_sec09", {sec_D10, sec_D1}, 8'h09);

        // Digit entry and rejection of a non-BCD digit
        pulse_enter(4'd5);
        check("enter5_load", Load_Input, 1);
        check("enter5_pi", Player_Input, 5);
        pulse_enter(4'd12);
        check("enter12_noload", Load_Input, 0);
        check("enter12_pi_held", Player_Input, 5);

        // Expiry with an enter on the expiry edge, then SCORE
        wait_until(48);
        enter_btn = 1'b1; digit_in = 4'd3;
        @(negedge clk);
        enter_btn = 1'b0;
        check("r1_timeout", Timeout, 1);
        check("r1_expiry_noload", Load_Input, 0);
        check("r1_sec00", {sec_D10, sec_D1}, 8'h00);
        wait_until(53);
        check("r1_score_busy", busy, 1);
        wait_until(54);
        check("r1_idle_busy", busy, 0);
        check("r1_still_logged", Logged_In, 1);
        check("r1_id_kept", playerID, 7);

        // Out-of-range login, then logout beats start
        pulse_logout();
        check("logout_logged", Logged_In, 0);
        pulse_login(5'd20);
        check("bad_id_logged", Logged_In, 0);
        pulse_login(5'd3);
        check("login3_id", playerID, 3);
        logout_req = 1'b1; start_btn = 1'b1;
        @(negedge clk);
        logout_req = 1'b0; start_btn = 1'b0;
        check("both_logged", Logged_In, 0);
        check("both_no_start", Game_Start, 0);
        @(negedge clk);
        check("both_busy", busy, 0);

        // Asynchronous reset mid-round
        pulse_login(5'd3);
        pulse_start();
        base = pos_cnt;
        wait_until(22);
        check("r2_sec07", {sec_D10, sec_D1}, 8'h07);
        #2 rst_n = 1'b0;
        #1;
        check("arst_logged", Logged_In, 0);
        check("arst_id", playerID, 0);
        check("arst_busy", busy, 0);
        check("arst_sec", {sec_D10, sec_D1}, 8'h00);
        check("arst_strobes", {Game_Start, Load_Input, Timeout}, 0);
        check("arst_pi", Player_Input, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        check("post_rst_no_start", Game_Start, 0);
        check("post_rst_busy", busy, 0);

        // Two back-to-back rounds for player 3 with strobe-order log
        obs_q.delete(); exp_q.delete();
        rec_en = 1'b1;
        pulse_login(5'd3);
        pulse_start();
        base = pos_cnt;
        wait_until(5);
        enter_btn = 1'b1; digit_in = 4'd4;
        @(negedge clk);
        check("b2b_load_a", Load_Input, 1);
        digit_in = 4'd6;
        @(negedge clk);
        enter_btn = 1'b0;
        check("b2b_load_b", Load_Input, 1);
        check("b2b_pi_b", Player_Input, 6);
        wait_until(54);
        check("r3_end_busy", busy, 0);
        pulse_start();
        base = pos_cnt;
        wait_until(10);
        pulse_enter(4'd1);
        wait_until(54);
        check("r4_end_busy", busy, 0);
        check("r4_id_held", playerID, 3);
        rec_en = 1'b0;

        exp_q = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
        check("strobe_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("strobe_order_%0d", i), obs_q[i], exp_q[i]);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
